// File: rtl/cva6_cfg_reader_pkg.sv
// Shared definitions for the configuration reader: word map, extension
// bitmap layout, FSM state type and the constant configuration table.
package cva6_cfg_reader_pkg;
    import cva6_config_pkg::*;

    localparam int unsigned NumWords = 21;
    localparam logic [31:0] CfgMagic = 32'h4356_4136;

    // Word indices
    localparam int unsigned IdxMagic      = 0;
    localparam int unsigned IdxXlen       = 1;
    localparam int unsigned IdxExt        = 2;
    localparam int unsigned IdxIcAssoc    = 3;
    localparam int unsigned IdxIcLines    = 4;
    localparam int unsigned IdxIcLineW    = 5;
    localparam int unsigned IdxDcAssoc    = 6;
    localparam int unsigned IdxDcLines    = 7;
    localparam int unsigned IdxDcLineW    = 8;
    localparam int unsigned IdxCommit     = 9;
    localparam int unsigned IdxSbEntries  = 10;
    localparam int unsigned IdxLoadRegs   = 11;
    localparam int unsigned IdxStoreRegs  = 12;
    localparam int unsigned IdxItlb       = 13;
    localparam int unsigned IdxDtlb       = 14;
    localparam int unsigned IdxRas        = 15;
    localparam int unsigned IdxBtb        = 16;
    localparam int unsigned IdxBht        = 17;
    localparam int unsigned IdxPmp        = 18;
    localparam int unsigned IdxFetchUserW = 19;
    localparam int unsigned IdxDataUserW  = 20;

    // Extension bitmap bit positions
    localparam int unsigned ExtFpu       = 0;
    localparam int unsigned ExtF16       = 1;
    localparam int unsigned ExtF16Alt    = 2;
    localparam int unsigned ExtF8        = 3;
    localparam int unsigned ExtFVec      = 4;
    localparam int unsigned ExtCvxif     = 5;
    localparam int unsigned ExtC         = 6;
    localparam int unsigned ExtA         = 7;
    localparam int unsigned ExtH         = 8;
    localparam int unsigned ExtFetchUser = 9;
    localparam int unsigned ExtDataUser  = 10;
    localparam int unsigned ExtRename    = 11;
    localparam int unsigned ExtFPGA      = 12;

    typedef enum logic {
        IDLE = 1'b0,
        DUMP = 1'b1
    } cfg_state_e;

    typedef logic [NumWords-1:0][31:0] cfg_table_t;

    function automatic logic [31:0] ext_bitmap();
        logic [31:0] b;
        b               = '0;
        b[ExtFpu]       = CVA6ConfigFpuEn;
        b[ExtF16]       = CVA6ConfigF16En;
        b[ExtF16Alt]    = CVA6ConfigF16AltEn;
        b[ExtF8]        = CVA6ConfigF8En;
        b[ExtFVec]      = CVA6ConfigFVecEn;
        b[ExtCvxif]     = CVA6ConfigCvxifEn;
        b[ExtC]         = CVA6ConfigCExtEn;
        b[ExtA]         = CVA6ConfigAExtEn;
        b[ExtH]         = CVA6ConfigHExtEn;
        b[ExtFetchUser] = CVA6ConfigFetchUserEn;
        b[ExtDataUser]  = CVA6ConfigDataUserEn;
        b[ExtRename]    = CVA6ConfigRenameEn;
        b[ExtFPGA]      = CVA6ConfigFPGAEn;
        return b;
    endfunction

    function automatic cfg_table_t build_table();
        cfg_table_t t;
        t                = '0;
        t[IdxMagic]      = CfgMagic;
        t[IdxXlen]       = 32'(CVA6ConfigXlen);
        t[IdxExt]        = ext_bitmap();
        t[IdxIcAssoc]    = 32'(CVA6ConfigIcacheSetAssoc);
        t[IdxIcLines]    = 32'(CVA6ConfigIcacheLines);
        t[IdxIcLineW]    = 32'(CVA6ConfigIcacheLineWidth);
        t[IdxDcAssoc]    = 32'(CVA6ConfigDcacheSetAssoc);
        t[IdxDcLines]    = 32'(CVA6ConfigDcacheLines);
        t[IdxDcLineW]    = 32'(CVA6ConfigDcacheLineWidth);
        t[IdxCommit]     = 32'(CVA6ConfigNrCommitPorts);
        t[IdxSbEntries]  = 32'(CVA6ConfigNrScoreboardEntries);
        t[IdxLoadRegs]   = 32'(CVA6ConfigNrLoadPipeRegs);
        t[IdxStoreRegs]  = 32'(CVA6ConfigNrStorePipeRegs);
        t[IdxItlb]       = 32'(CVA6ConfigInstrTlbEntries);
        t[IdxDtlb]       = 32'(CVA6ConfigDataTlbEntries);
        t[IdxRas]        = 32'(CVA6ConfigRASDepth);
        t[IdxBtb]        = 32'(CVA6ConfigBTBEntries);
        t[IdxBht]        = 32'(CVA6ConfigBHTEntries);
        t[IdxPmp]        = 32'(CVA6ConfigNrPMPEntries);
        t[IdxFetchUserW] = 32'(CVA6ConfigFetchUserWidth);
        t[IdxDataUserW]  = 32'(CVA6ConfigDataUserWidth);
        return t;
    endfunction

    localparam cfg_table_t CfgTable = build_table();

endpackage

// File: rtl/cva6_config_pkg.sv
// Core compile-time configuration constants consumed by the configuration
// reader. Values describe the 64-bit application-class core build.
package cva6_config_pkg;

    localparam int unsigned CVA6ConfigXlen              = 64;

    localparam bit          CVA6ConfigFpuEn             = 1'b1;
    localparam bit          CVA6ConfigF16En             = 1'b0;
    localparam bit          CVA6ConfigF16AltEn          = 1'b0;
    localparam bit          CVA6ConfigF8En              = 1'b0;
    localparam bit          CVA6ConfigFVecEn            = 1'b0;
    localparam bit          CVA6ConfigCvxifEn           = 1'b1;
    localparam bit          CVA6ConfigCExtEn            = 1'b1;
    localparam bit          CVA6ConfigAExtEn            = 1'b1;
    localparam bit          CVA6ConfigHExtEn            = 1'b1;
    localparam bit          CVA6ConfigFetchUserEn       = 1'b0;
    localparam bit          CVA6ConfigDataUserEn        = 1'b0;
    localparam bit          CVA6ConfigRenameEn          = 1'b0;
    localparam bit          CVA6ConfigFPGAEn            = 1'b0;

    localparam int unsigned CVA6ConfigIcacheSetAssoc    = 4;
    localparam int unsigned CVA6ConfigIcacheLines       = 4096;
    localparam int unsigned CVA6ConfigIcacheLineWidth   = 128;
    localparam int unsigned CVA6ConfigDcacheSetAssoc    = 8;
    localparam int unsigned CVA6ConfigDcacheLines       = 4096;
    localparam int unsigned CVA6ConfigDcacheLineWidth   = 128;

    localparam int unsigned CVA6ConfigNrCommitPorts     = 2;
    localparam int unsigned CVA6ConfigNrScoreboardEntries = 8;
    localparam int unsigned CVA6ConfigNrLoadPipeRegs    = 1;
    localparam int unsigned CVA6ConfigNrStorePipeRegs   = 0;
    localparam int unsigned CVA6ConfigInstrTlbEntries   = 16;
    localparam int unsigned CVA6ConfigDataTlbEntries    = 16;
    localparam int unsigned CVA6ConfigRASDepth          = 2;
    localparam int unsigned CVA6ConfigBTBEntries        = 32;
    localparam int unsigned CVA6ConfigBHTEntries        = 128;
    localparam int unsigned CVA6ConfigNrPMPEntries      = 8;
    localparam int unsigned CVA6ConfigFetchUserWidth    = 32;
    localparam int unsigned CVA6ConfigDataUserWidth     = 32;

endpackage

// File: rtl/cva6_cfg_reader_if.sv
// Read port and dump stream bundle of the configuration reader.
// Optional macro CVA6_CFG_READER_PARITY_EN adds the two parity outputs.
interface cva6_cfg_reader_if #(
    parameter int unsigned AddrWidth = 5,
    parameter int unsigned DataWidth = 32
);
    logic                 req_i;
    logic [AddrWidth-1:0] addr_i;
    logic                 gnt_o;
    logic                 rvalid_o;
    logic [DataWidth-1:0] rdata_o;
    logic                 rerr_o;
    logic                 dump_i;
    logic                 dump_valid_o;
    logic                 dump_ready_i;
    logic [DataWidth-1:0] dump_data_o;
    logic                 dump_last_o;
    logic                 dump_busy_o;
`ifdef CVA6_CFG_READER_PARITY_EN
    logic                 rdata_par_o;
    logic                 dump_par_o;
`endif

    // Responder side
    modport slave (
        input  req_i, addr_i, dump_i, dump_ready_i,
        output gnt_o, rvalid_o, rdata_o, rerr_o,
        output dump_valid_o, dump_data_o, dump_last_o, dump_busy_o
`ifdef CVA6_CFG_READER_PARITY_EN
        , output rdata_par_o, dump_par_o
`endif
    );

    // Requester / stream sink side
    modport master (
        output req_i, addr_i, dump_i, dump_ready_i,
        input  gnt_o, rvalid_o, rdata_o, rerr_o,
        input  dump_valid_o, dump_data_o, dump_last_o, dump_busy_o
`ifdef CVA6_CFG_READER_PARITY_EN
        , input rdata_par_o, dump_par_o
`endif
    );
endinterface

// File: rtl/cva6_cfg_rom.sv
// Combinational index -> (word, out-of-range flag) lookup into the
// constant configuration table. Out-of-range indices return zero data.
module cva6_cfg_rom
    import cva6_cfg_reader_pkg::*;
#(
    parameter int unsigned AddrWidth = 5,
    parameter int unsigned DataWidth = 32
) (
    input  logic [AddrWidth-1:0] idx_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 err_o
);

    // Table lookup with zero-extension to the port width
    always_comb begin
        data_o = '0;
        err_o  = 1'b1;
        if (32'(idx_i) < NumWords) begin
            data_o = DataWidth'(CfgTable[idx_i]);
            err_o  = 1'b0;
        end
    end

endmodule

// File: rtl/cva6_cfg_reader.sv
// Configuration reader: random-access read port (combinational grant,
// one-cycle registered response) plus a valid/ready dump engine that
// streams the whole table. Two ROM lookups avoid any read/dump arbitration.
// Optional macro CVA6_CFG_READER_PARITY_EN adds even-parity outputs.
module cva6_cfg_reader
    import cva6_cfg_reader_pkg::*;
#(
    parameter int unsigned AddrWidth = 5,
    parameter int unsigned DataWidth = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    cva6_cfg_reader_if.slave   bus
);

    localparam logic [AddrWidth-1:0] LastIdx = AddrWidth'(NumWords - 1);

    cfg_state_e           state_q;
    logic [AddrWidth-1:0] dump_idx_q, dump_idx_d;
    logic                 rvalid_q, rerr_q;
    logic [DataWidth-1:0] rdata_q;
    logic                 dump_valid_q, dump_last_q;
    logic [DataWidth-1:0] dump_data_q;
`ifdef CVA6_CFG_READER_PARITY_EN
    logic                 rdata_par_q, dump_par_q;
`endif

    logic                 gnt;
    logic [DataWidth-1:0] rd_data, dp_data;
    logic                 rd_err;
    logic                 dp_err_unused;

    // Reads are only served while the dump engine is idle
    assign gnt = bus.req_i && (state_q == IDLE);

    cva6_cfg_rom #(.AddrWidth(AddrWidth), .DataWidth(DataWidth)) u_rd_rom (
        .idx_i  (bus.addr_i),
        .data_o (rd_data),
        .err_o  (rd_err)
    );

    // The dump ROM looks up the next index so the stream word is registered
    cva6_cfg_rom #(.AddrWidth(AddrWidth), .DataWidth(DataWidth)) u_dp_rom (
        .idx_i  (dump_idx_d),
        .data_o (dp_data),
        .err_o  (dp_err_unused)
    );

    // Next dump index: restart at 0 from IDLE, advance on each non-final handshake
    always_comb begin
        dump_idx_d = dump_idx_q;
        if (state_q == IDLE) begin
            dump_idx_d = '0;
        end else if (bus.dump_ready_i && (dump_idx_q != LastIdx)) begin
            dump_idx_d = dump_idx_q + 1'b1;
        end
    end

    // Read response register: valid for one cycle per grant, data held otherwise
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rerr_q      <= 1'b0;
`ifdef CVA6_CFG_READER_PARITY_EN
            rdata_par_q <= 1'b0;
`endif
        end else begin
            rvalid_q <= gnt;
            if (gnt) begin
                rdata_q     <= rd_data;
                rerr_q      <= rd_err;
`ifdef CVA6_CFG_READER_PARITY_EN
                rdata_par_q <= ^rd_data;
`endif
            end
        end
    end

    // Dump FSM with registered stream outputs; words only change on handshake
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            dump_idx_q   <= '0;
            dump_valid_q <= 1'b0;
            dump_last_q  <= 1'b0;
            dump_data_q  <= '0;
`ifdef CVA6_CFG_READER_PARITY_EN
            dump_par_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.dump_i) begin
                        state_q      <= DUMP;
                        dump_idx_q   <= dump_idx_d;
                        dump_valid_q <= 1'b1;
                        dump_data_q  <= dp_data;
                        dump_last_q  <= (dump_idx_d == LastIdx);
`ifdef CVA6_CFG_READER_PARITY_EN
                        dump_par_q   <= ^dp_data;
`endif
                    end
                end
                DUMP: begin
                    if (bus.dump_ready_i) begin
                        if (dump_last_q) begin
                            state_q      <= IDLE;
                            dump_idx_q   <= '0;
                            dump_valid_q <= 1'b0;
                            dump_last_q  <= 1'b0;
                            dump_data_q  <= '0;
`ifdef CVA6_CFG_READER_PARITY_EN
                            dump_par_q   <= 1'b0;
`endif
                        end else begin
                            dump_idx_q   <= dump_idx_d;
                            dump_data_q  <= dp_data;
                            dump_last_q  <= (dump_idx_d == LastIdx);
`ifdef CVA6_CFG_READER_PARITY_EN
                            dump_par_q   <= ^dp_data;
`endif
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt_o        = gnt;
    assign bus.rvalid_o     = rvalid_q;
    assign bus.rdata_o      = rdata_q;
    assign bus.rerr_o       = rerr_q;
    assign bus.dump_valid_o = dump_valid_q;
    assign bus.dump_data_o  = dump_data_q;
    assign bus.dump_last_o  = dump_last_q;
    assign bus.dump_busy_o  = (state_q == DUMP);
`ifdef CVA6_CFG_READER_PARITY_EN
    assign bus.rdata_par_o  = rdata_par_q;
    assign bus.dump_par_o   = dump_par_q;
`endif

endmodule

// File: tb/tb_cva6_cfg_reader.sv
// Scoreboard bench for cva6_cfg_reader: expected read responses and dump
// words are queued when stimulus is driven and checked as the DUT emits them.
module tb_cva6_cfg_reader;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        last;
    } exp_t;

    localparam logic [31:0] TBL [21] = '{
        32'h4356_4136, 32'd64, 32'h0000_01E1, 32'd4, 32'd4096, 32'd128,
        32'd8, 32'd4096, 32'd128, 32'd2, 32'd8, 32'd1, 32'd0, 32'd16,
        32'd16, 32'd2, 32'd32, 32'd128, 32'd8, 32'd32, 32'd32
    };

    logic clk;
    logic rst_ni;
    int   total;
    int   bad;
    exp_t rd_q[$];
    exp_t dq[$];

    cva6_cfg_reader_if #(.AddrWidth(5), .DataWidth(32)) bus ();

    cva6_cfg_reader #(.AddrWidth(5), .DataWidth(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compares every response/stream word against the queue fronts
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_ni) begin
                if (bus.rvalid_o) begin
                    total++;
                    if (rd_q.size() == 0) begin
                        bad++;
                        $display("FAIL rd_unexpected: rvalid_o=1 with no read outstanding, rdata=%h", bus.rdata_o);
                    end else begin
                        e = rd_q.pop_front();
                        if (bus.rdata_o !== e.data || bus.rerr_o !== e.err) begin
                            bad++;
                            $display("FAIL rd_resp: got data=%h err=%b, want data=%h err=%b",
                                     bus.rdata_o, bus.rerr_o, e.data, e.err);
                        end
`ifdef CVA6_CFG_READER_PARITY_EN
                        total++;
                        if (bus.rdata_par_o !== ^e.data) begin
                            bad++;
                            $display("FAIL rd_par: got %b want %b", bus.rdata_par_o, ^e.data);
                        end
`endif
                    end
                end
                if (bus.dump_valid_o) begin
                    total++;
                    if (dq.size() == 0) begin
                        bad++;
                        $display("FAIL dump_unexpected: dump_valid_o=1 with no word expected, data=%h", bus.dump_data_o);
                    end else begin
                        e = dq[0];
                        if (bus.dump_data_o !== e.data || bus.dump_last_o !== e.last) begin
                            bad++;
                            $display("FAIL dump_word: got data=%h last=%b, want data=%h last=%b",
                                     bus.dump_data_o, bus.dump_last_o, e.data, e.last);
                        end
`ifdef CVA6_CFG_READER_PARITY_EN
                        total++;
                        if (bus.dump_par_o !== ^e.data) begin
                            bad++;
                            $display("FAIL dump_par: got %b want %b", bus.dump_par_o, ^e.data);
                        end
`endif
                        if (bus.dump_ready_i) void'(dq.pop_front());
                    end
                end
            end
        end
    endtask

    // Drives one request cycle (caller is at posedge+1); checks the grant
    task automatic issue_read(input logic [4:0] a);
        exp_t e;
        bus.req_i  = 1'b1;
        bus.addr_i = a;
        @(negedge clk);
        total++;
        if (bus.gnt_o !== 1'b1) begin
            bad++;
            $display("FAIL rd_gnt: addr=%0d gnt_o=%b want 1", a, bus.gnt_o);
        end
        e.data = (a < 21) ? TBL[a] : 32'h0;
        e.err  = (a >= 21);
        e.last = 1'b0;
        rd_q.push_back(e);
        step();
    endtask

    // Response must have been consumed by the very next negedge
    task automatic check_rd_drained(input string name);
        @(negedge clk);
        #1;
        total++;
        if (rd_q.size() != 0) begin
            bad++;
            $display("FAIL %s: %0d responses outstanding, want 0", name, rd_q.size());
            rd_q.delete();
        end
    endtask

    task automatic push_dump();
        exp_t e;
        for (int i = 0; i < 21; i++) begin
            e.data = TBL[i];
            e.err  = 1'b0;
            e.last = (i == 20);
            dq.push_back(e);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) step();
        total++;
        if ({bus.gnt_o, bus.rvalid_o, bus.rdata_o, bus.rerr_o, bus.dump_valid_o,
             bus.dump_data_o, bus.dump_last_o, bus.dump_busy_o} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: rvalid=%b rdata=%h dvalid=%b ddata=%h busy=%b, want all 0",
                     bus.rvalid_o, bus.rdata_o, bus.dump_valid_o, bus.dump_data_o, bus.dump_busy_o);
        end
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_read();
        issue_read(5'd0);  bus.req_i = 1'b0; check_rd_drained("rd_magic");
        step();
        issue_read(5'd1);  bus.req_i = 1'b0; check_rd_drained("rd_xlen");
        step();
        issue_read(5'd18); bus.req_i = 1'b0; check_rd_drained("rd_pmp");
        step();
        issue_read(5'd20); bus.req_i = 1'b0; check_rd_drained("rd_last_idx");
        step();
    endtask

    task automatic test_out_of_range();
        issue_read(5'd25); bus.req_i = 1'b0; check_rd_drained("rd_oor25");
        step();
        issue_read(5'd21); bus.req_i = 1'b0; check_rd_drained("rd_oor21");
        step();
    endtask

    task automatic test_back_to_back();
        issue_read(5'd4);
        issue_read(5'd7);
        issue_read(5'd17);
        bus.req_i = 1'b0;
        check_rd_drained("rd_b2b");
        step();
    endtask

    task automatic test_dump_stall();
        int n;
        bus.dump_i       = 1'b1;
        bus.dump_ready_i = 1'b0;
        push_dump();
        step();
        bus.dump_i = 1'b0;
        bus.addr_i = 5'd3;
        n = 0;
        while (dq.size() != 0 && n < 200) begin
            bus.dump_ready_i = ~bus.dump_ready_i;
            bus.req_i        = bus.dump_busy_o;
            @(negedge clk);
            if (bus.req_i) begin
                total++;
                if (bus.gnt_o !== 1'b0) begin
                    bad++;
                    $display("FAIL dump_no_gnt: gnt_o=%b during dump, want 0", bus.gnt_o);
                end
            end
            step();
            n++;
        end
        bus.req_i        = 1'b0;
        bus.dump_ready_i = 1'b0;
        total++;
        if (n >= 200) begin
            bad++;
            $display("FAIL dump_timeout: %0d words never seen", dq.size());
            dq.delete();
        end
        total++;
        if (bus.dump_busy_o !== 1'b0 || bus.dump_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL dump_end: busy=%b valid=%b after last handshake, want 0 0",
                     bus.dump_busy_o, bus.dump_valid_o);
        end
        step();
    endtask

    task automatic test_read_and_dump();
        exp_t e;
        int   n;
        bus.req_i        = 1'b1;
        bus.addr_i       = 5'd2;
        bus.dump_i       = 1'b1;
        bus.dump_ready_i = 1'b1;
        @(negedge clk);
        total++;
        if (bus.gnt_o !== 1'b1) begin
            bad++;
            $display("FAIL simul_gnt: gnt_o=%b want 1", bus.gnt_o);
        end
        e.data = 32'h0000_01E1; e.err = 1'b0; e.last = 1'b0;
        rd_q.push_back(e);
        push_dump();
        step();
        bus.req_i  = 1'b0;
        bus.dump_i = 1'b0;
        @(negedge clk);
        total++;
        if (bus.rvalid_o !== 1'b1 || bus.dump_busy_o !== 1'b1) begin
            bad++;
            $display("FAIL simul_first_dump_cycle: rvalid=%b busy=%b want 1 1",
                     bus.rvalid_o, bus.dump_busy_o);
        end
        step();
        n = 1;
        while (dq.size() != 0 && n < 60) begin
            step();
            n++;
        end
        total++;
        if (n != 21) begin
            bad++;
            $display("FAIL dump_length: %0d cycles with ready high, want 21", n);
            dq.delete();
        end
        total++;
        if (bus.dump_busy_o !== 1'b0) begin
            bad++;
            $display("FAIL simul_busy_end: busy=%b want 0", bus.dump_busy_o);
        end
        bus.dump_ready_i = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_dump();
        int n;
        bus.dump_i       = 1'b1;
        bus.dump_ready_i = 1'b1;
        push_dump();
        step();
        bus.dump_i = 1'b0;
        n = 0;
        while (dq.size() > 11 && n < 60) begin
            step();
            n++;
        end
        #1;
        rst_ni = 1'b0;
        #1;
        total++;
        if ({bus.gnt_o, bus.rvalid_o, bus.rdata_o, bus.rerr_o, bus.dump_valid_o,
             bus.dump_data_o, bus.dump_last_o, bus.dump_busy_o} !== '0) begin
            bad++;
            $display("FAIL reset_mid_dump: dvalid=%b ddata=%h busy=%b rdata=%h, want all 0",
                     bus.dump_valid_o, bus.dump_data_o, bus.dump_busy_o, bus.rdata_o);
        end
        dq.delete();
        rd_q.delete();
        step();
        step();
        rst_ni = 1'b1;
        repeat (5) step();
        total++;
        if (bus.dump_valid_o !== 1'b0 || bus.dump_busy_o !== 1'b0 || bus.rvalid_o !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_quiet: dvalid=%b busy=%b rvalid=%b want 0 0 0",
                     bus.dump_valid_o, bus.dump_busy_o, bus.rvalid_o);
        end
        bus.dump_ready_i = 1'b0;
        issue_read(5'd1);
        bus.req_i = 1'b0;
        check_rd_drained("rd_after_reset");
`ifdef CVA6_CFG_READER_PARITY_EN
        total++;
        if (bus.rdata_par_o !== 1'b1) begin
            bad++;
            $display("FAIL rdata_par_word1: got %b want 1", bus.rdata_par_o);
        end
`endif
        step();
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        rst_ni           = 1'b0;
        bus.req_i        = 1'b0;
        bus.addr_i       = '0;
        bus.dump_i       = 1'b0;
        bus.dump_ready_i = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_read();
        test_out_of_range();
        test_back_to_back();
        test_dump_stall();
        test_read_and_dump();
        test_reset_mid_dump();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cva6_cfg_reader.md
# cva6_cfg_reader

Read-only responder that exposes the core's compile-time configuration (the `cva6_config_pkg` constants) as a table of 32-bit words to debug and SoC software. It offers a random-access read port with a request/grant handshake and fixed one-cycle response, and a streaming dump engine that emits the whole table over valid/ready on command. It sits beside the CSR/debug fabric and has no timing path into the core pipeline.

## Interface
- `AddrWidth`, default 5: word index width; must hold `NumWords`.
- `DataWidth`, default 32: word width; every entry is zero-extended to this width.
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `req_i` in 1: read request.
- `addr_i` in AddrWidth: word index.
- `gnt_o` out 1: request accepted this cycle.
- `rvalid_o` out 1: response valid.
- `rdata_o` out DataWidth: response data.
- `rerr_o` out 1: response is for an out-of-range index.
- `dump_i` in 1: start-dump pulse.
- `dump_valid_o` out 1: stream word valid.
- `dump_ready_i` in 1: stream sink ready.
- `dump_data_o` out DataWidth: stream word.
- `dump_last_o` out 1: final word of the dump.
- `dump_busy_o` out 1: dump engine active.

## Operation
- Word map, `NumWords` = 21:
  - 0 = 0x43564136.
  - 1 = XLEN.
  - 2 = extension bitmap:
    - bits 0–4: Fpu, F16, F16Alt, F8, FVec.
    - bits 5–8: Cvxif, C, A, H.
    - bits 9–12: FetchUser, DataUser, Rename, FPGA.
    - all other bits 0.
  - 3–5 = icache set-assoc, lines, line width.
  - 6–8 = dcache set-assoc, lines, line width.
  - 9 = commit ports.
  - 10 = scoreboard entries.
  - 11 = load pipe registers.
  - 12 = store pipe registers.
  - 13 = ITLB entries.
  - 14 = DTLB entries.
  - 15 = RAS depth.
  - 16 = BTB entries.
  - 17 = BHT entries.
  - 18 = PMP entries.
  - 19 = fetch user width.
  - 20 = data user width.
- FSM states: `IDLE` and `DUMP`.
- `gnt_o` = `req_i` and (state == `IDLE`). The grant is combinational and there is no requester backpressure.
- Read response for an index below 21: `rdata_o` = word, `rerr_o` = 0.
- Read response for an index of 21 or more: `rdata_o` = 0, `rerr_o` = 1.
- `IDLE` → `DUMP` on `dump_i`. The dump index is set to 0.
- In `DUMP`:
  - `dump_valid_o` = 1 and `dump_data_o` = word[idx].
  - The index increments on each `dump_valid_o` & `dump_ready_i` handshake.
  - `dump_last_o` = 1 when idx = 20.
  - `DUMP` → `IDLE` on the handshake of the last word.
- `dump_i` is ignored while in `DUMP`.
- `dump_busy_o` = (state == `DUMP`).

## Timing
- `rvalid_o` is asserted exactly one cycle after each `gnt_o`. It is high for one cycle per grant, so back-to-back grants give back-to-back responses.
- `rdata_o` and `rerr_o` are registered and hold their last value while `rvalid_o` is low.
- Simultaneous `req_i` and `dump_i` in `IDLE`: the read is granted and `DUMP` is entered on the next edge. That read's response still appears in the first `DUMP` cycle.
- Requests are not granted while in `DUMP`.
- Stream rules: once asserted, `dump_valid_o`, `dump_data_o` and `dump_last_o` hold stable until the handshake.
- A dump takes a minimum of 21 cycles with `dump_ready_i` held high, plus 1 cycle of entry latency after `dump_i`.
- Reset values of all outputs are 0, and the FSM resets to `IDLE`.
- Reset mid-dump or mid-read aborts the operation. No response or stream word is issued after reset deasserts until a new request or `dump_i`.

## Configuration
- Macro: `CVA6_CFG_READER_PARITY_EN`.
- Defined:
  - Adds out ports `rdata_par_o` and `dump_par_o`, each 1 bit.
  - Each carries the even parity (XOR) of `rdata_o` and `dump_data_o` respectively, including the `rerr_o` zero word.
  - Both ports reset to 0.
  - `rdata_par_o` follows the same register timing as `rdata_o`.
- Undefined: the ports and their logic are absent. All other behaviour is identical.

## Structure
- Shared package `cva6_cfg_reader_pkg` holds:
  - `NumWords` = 21.
  - The magic constant 0x43564136.
  - Named word-index localparams.
  - The extension-bitmap bit positions.
  - A `cfg_state_e` enum (`IDLE`, `DUMP`).
- The table is built as a constant array from `cva6_config_pkg`.
- Sub-module `cva6_cfg_rom`: a combinational lookup of index → (data, err).
  - It is instantiated twice: once for the read port and once for the dump index.
  - This removes any arbitration between the read port and the dump engine.

## Test plan
- Read: `req_i` with `addr_i` = 0 → same-cycle `gnt_o`; next cycle `rvalid_o` = 1, `rdata_o` = 0x43564136, `rerr_o` = 0. `addr_i` = 1 → 64. `addr_i` = 18 → 8.
- Out-of-range read: `addr_i` = 25 → `rvalid_o` = 1, `rerr_o` = 1, `rdata_o` = 0.
- Back-to-back reads of indices 4, 7, 17 on consecutive cycles → responses 4096, 4096, 128 on consecutive cycles.
- Dump with `dump_ready_i` toggling 1/0 each cycle:
  - 21 words in order, with stable data while stalled.
  - `dump_last_o` only on word 20.
  - Reads not granted during the dump.
  - `dump_busy_o` falls after the last handshake.
- Simultaneous `req_i` (`addr_i` = 2) and `dump_i` in `IDLE` → read granted, response 0x1E1, dump starts next cycle.
- Assert `rst_ni` low during word 10 of a dump → all outputs 0 immediately. After release, no stream activity until `dump_i`. With `CVA6_CFG_READER_PARITY_EN` defined, `rdata_par_o` = 1 for word 1 (64).
